// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID/EX load and the IF/ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);
  assign load_use = ex_memread && ex_rt != REG_ZERO &&
                    (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with memory wait FSM and timeout.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_memread,
  input  logic [4:0]         ex_rt,
  input  logic               mem_branch,
  input  logic               mem_zero,
  input  logic               mem_access,
  input  logic               dmem_ready,
  output logic               pc_en,
  output logic               pc_src,
  output logic               if_id_en,
  output logic               id_ex_en,
  output logic               ex_mem_en,
  output logic               mem_wb_en,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               ex_mem_flush,
  output logic [STATE_W-1:0] ctrl_state,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_events
);
  localparam int WCW = $clog2(MAX_WAIT);
  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           load_use;
  logic           mem_stall;
  logic           taken;
  logic           advance;
  hazard_detect u_hazard (
    .ex_memread(ex_memread),
    .ex_rt(ex_rt),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_uses_rt(id_uses_rt),
    .load_use(load_use)
  );
  assign ctrl_state = state;
  // A taken branch squashes the ID instruction, so it masks any load-use stall.
  always_comb begin
    mem_stall    = mem_access && !dmem_ready;
    taken        = mem_branch && mem_zero;
    advance      = (state == RUN && !mem_stall) || (state == MEM_WAIT && dmem_ready);
    pc_en        = rst_n && advance && (taken || !load_use);
    pc_src       = rst_n && advance && taken;
    if_id_en     = !rst_n || (advance && (taken || !load_use));
    id_ex_en     = !rst_n || advance;
    ex_mem_en    = !rst_n || advance;
    mem_wb_en    = !rst_n || advance;
    if_id_flush  = !rst_n || (advance && taken);
    id_ex_flush  = !rst_n || (advance && (taken || load_use));
    ex_mem_flush = !rst_n || (advance && taken);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_stall) begin
          state    <= MEM_WAIT;
          wait_cnt <= WCW'(1);
        end
        MEM_WAIT: if (dmem_ready) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
          state       <= ERROR;
          err_timeout <= 1'b1;
        end else wait_cnt <= wait_cnt + WCW'(1);
        ERROR: state <= ERROR;
        default: state <= RUN;
      endcase
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_src && !(&flush_events)) flush_events <= flush_events + CNT_W'(1);
    end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, corner sequences and randomized model comparison for pipeline_ctrl
module tb_pipeline_ctrl;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W = 32;
  localparam logic [8:0] C_R = 9'b0_0_1111_111;
  localparam logic [8:0] C_A = 9'b1_0_1111_000;
  localparam logic [8:0] C_L = 9'b0_0_0111_010;
  localparam logic [8:0] C_B = 9'b1_1_1111_111;
  localparam logic [8:0] C_S = 9'b0_0_0000_000;
  logic clk = 1'b0;
  logic rst_n, id_uses_rt, ex_memread, mem_branch, mem_zero, mem_access, dmem_ready;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, err_timeout;
  logic [1:0] ctrl_state;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [8:0] ctl;
  int tests = 0, fails = 0;
  int m_len = 0;
  bit m_err = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_en(pc_en), .pc_src(pc_src),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .ctrl_state(ctrl_state), .err_timeout(err_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );
  always #5 clk = ~clk;
  assign ctl = {pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush};
  typedef struct {
    logic rst_n;
    logic [4:0] id_rs, id_rt;
    logic uses_rt, memread;
    logic [4:0] ex_rt;
    logic branch, zero, access, ready;
    logic [8:0] exp_ctl;
    logic [1:0] exp_state;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic u,
                        input logic mr, input logic [4:0] ert, input logic br, input logic z,
                        input logic acc, input logic rdy);
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = u; ex_memread = mr; ex_rt = ert;
    mem_branch = br; mem_zero = z; mem_access = acc; dmem_ready = rdy;
  endtask
  // Reference: stalls are counted as a run of consecutive unready cycles; the run limit is the timeout.
  function automatic bit model_stalled();
    return (m_len == 0) ? (mem_access && !dmem_ready) : !dmem_ready;
  endfunction
  function automatic logic [8:0] model_ctl();
    bit lu;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (!rst_n) return C_R;
    if (m_err || model_stalled()) return C_S;
    if (mem_branch && mem_zero) return C_B;
    if (lu) return C_L;
    return C_A;
  endfunction
  function automatic logic [1:0] model_state();
    return m_err ? 2'd2 : (m_len > 0 ? 2'd1 : 2'd0);
  endfunction
  task automatic tick();
    logic [8:0] c;
    @(posedge clk);
    c = model_ctl();
    if (!rst_n) begin
      m_len = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (!c[8] && m_stall != '1) m_stall = m_stall + 1;
      if (c == C_B && m_flush != '1) m_flush = m_flush + 1;
      if (!m_err) begin
        if (model_stalled()) begin
          m_len++;
          if (m_len == MAX_WAIT) begin m_err = 1; m_len = 0; end
        end else m_len = 0;
      end
    end
    #1;
  endtask
  task automatic step(input string name);
    @(negedge clk);
    check({name, " ctl"}, 64'(ctl), 64'(model_ctl()));
    check({name, " state"}, 64'(ctrl_state), 64'(model_state()));
    check({name, " err"}, 64'(err_timeout), 64'(m_err));
`ifdef PIPE_CTRL_PERF_CNT_EN
    check({name, " stall_cnt"}, 64'(stall_cycles), 64'(m_stall));
    check({name, " flush_cnt"}, 64'(flush_events), 64'(m_flush));
`else
    check({name, " stall_cnt"}, 64'(stall_cycles), 64'd0);
    check({name, " flush_cnt"}, 64'(flush_events), 64'd0);
`endif
    tick();
  endtask
  initial begin
    vecs = '{
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_R, 2'd0},
      '{0, 8, 0, 0, 1, 8, 1, 1, 1, 0, C_R, 2'd0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 2'd0},
      '{1, 8, 0, 0, 1, 8, 0, 0, 0, 0, C_L, 2'd0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 2'd0},
      '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_A, 2'd0},
      '{1, 1, 5, 1, 1, 5, 0, 0, 0, 0, C_L, 2'd0},
      '{1, 1, 5, 0, 1, 5, 0, 0, 0, 0, C_A, 2'd0},
      '{1, 8, 0, 0, 1, 8, 1, 1, 0, 0, C_B, 2'd0},
      '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_A, 2'd0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_S, 2'd0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_S, 2'd1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_S, 2'd1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_S, 2'd1},
      '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1, C_B, 2'd1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 2'd0},
      '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_A, 2'd0},
      '{1, 3, 0, 0, 1, 3, 0, 0, 1, 0, C_S, 2'd0},
      '{1, 3, 0, 0, 1, 3, 0, 0, 1, 1, C_L, 2'd1},
      '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_A, 2'd0}
    };
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tick();
    foreach (vecs[i]) begin
      set_in(vecs[i].rst_n, vecs[i].id_rs, vecs[i].id_rt, vecs[i].uses_rt, vecs[i].memread,
             vecs[i].ex_rt, vecs[i].branch, vecs[i].zero, vecs[i].access, vecs[i].ready);
      @(negedge clk);
      check($sformatf("vec%0d ctl", i), 64'(ctl), 64'(vecs[i].exp_ctl));
      check($sformatf("vec%0d state", i), 64'(ctrl_state), 64'(vecs[i].exp_state));
      tick();
    end
    // Timeout: sixteen consecutive unready cycles, then sticky ERROR until reset.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MAX_WAIT; i++) step("timeout_wait");
    @(negedge clk);
    check("timeout_state", 64'(ctrl_state), 64'd2);
    check("timeout_err", 64'(err_timeout), 64'd1);
    check("timeout_ctl", 64'(ctl), 64'(C_S));
    tick();
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    step("error_hold");
    step("error_hold");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("error_reset");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_reset_err", 64'(err_timeout), 64'd0);
    check("post_reset_state", 64'(ctrl_state), 64'd0);
    tick();
`ifdef PIPE_CTRL_PERF_CNT_EN
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 8, 0, 0, 1, 8, 0, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("perf_stall5", 64'(stall_cycles), 64'd5);
    check("perf_flush0", 64'(flush_events), 64'd0);
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("perf_flush3", 64'(flush_events), 64'd3);
    tick();
`endif
    for (int i = 0; i < 3000; i++) begin
      bit slow;
      slow = (i / 400) % 2 == 1;
      set_in($urandom_range(0, 59) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) != 0));
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
